// File: rtl/spi_sensor_pkg.sv
// rtl/spi_sensor_pkg.sv - shared op encodings, FSM state type and constants for the SPI sensor responder
package spi_sensor_pkg;

    localparam logic [1:0] OP_CONVERT = 2'b00;
    localparam logic [1:0] OP_CALIB   = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    localparam logic [7:0] WRITE_ACK_TAG = 8'hFF;

    // Register storage is sized for the full 6-bit address space; slots at or
    // above REG_COUNT are never written and trim away.
    localparam int REG_SLOTS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/spi_sensor_responder_if.sv
// rtl/spi_sensor_responder_if.sv - SPI pin bundle between the main controller and the sensor responder
interface spi_sensor_responder_if;
    logic SCLK_wire;
    logic CS_b_wire;
    logic MOSI_to_sensor;
    logic MISO_from_sensor;

    modport master (
        output SCLK_wire,
        output CS_b_wire,
        output MOSI_to_sensor,
        input  MISO_from_sensor
    );

    modport slave (
        input  SCLK_wire,
        input  CS_b_wire,
        input  MOSI_to_sensor,
        output MISO_from_sensor
    );
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchronizer with rise/fall pulses on the synchronized value
module spi_sync_edge #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_b,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;
endmodule

// File: rtl/spi_sensor_responder.sv
// rtl/spi_sensor_responder.sv - SPI mode-0 sensor emulator: command decode, register file, delayed result pipeline
module spi_sensor_responder
    import spi_sensor_pkg::*;
#(
    parameter int PIPE_DEPTH = 2,
    parameter int REG_COUNT  = 32,
    parameter int FRAME_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset_b,
    spi_sensor_responder_if.slave  spi,
    output logic                   frame_valid,
    output logic [15:0]            last_cmd,
    output logic                   frame_err,
    output logic [31:0]            frame_count
);
    localparam logic [6:0] REG_LIMIT = 7'(REG_COUNT);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic sclk_sync_unused, cs_sync_unused, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk (
        .clk(clk), .reset_b(reset_b), .async_in(spi.SCLK_wire),
        .sync_out(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    // CS_b idles high, so its synchronizer resets high to avoid a false edge.
    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs (
        .clk(clk), .reset_b(reset_b), .async_in(spi.CS_b_wire),
        .sync_out(cs_sync_unused), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi (
        .clk(clk), .reset_b(reset_b), .async_in(spi.MOSI_to_sensor),
        .sync_out(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    fsm_state_t  state, state_next;
    logic [4:0]  bit_cnt;
    logic [15:0] rx_word, tx_word;
    logic        miso_q;
    logic [15:0] pipe [PIPE_DEPTH];
    logic [7:0]  reg_file [REG_SLOTS];

    logic load_frame, shift_bit, drive_bit, accept, abort;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_frame = 1'b0;
        shift_bit  = 1'b0;
        drive_bit  = 1'b0;
        accept     = 1'b0;
        abort      = 1'b0;
        if (cs_fall) begin
            state_next = SHIFT;
            load_frame = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                SHIFT: begin
                    // CS_b rising takes precedence over any SCLK edge in the same clk.
                    if (cs_rise) begin
                        state_next = IDLE;
                        abort      = 1'b1;
                    end else if (sclk_rise) begin
                        shift_bit = 1'b1;
                        if (bit_cnt == 5'd15) state_next = DONE;
                    end else if (sclk_fall && bit_cnt != 5'd0) begin
                        drive_bit = 1'b1;
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        state_next = IDLE;
                        accept     = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    logic [1:0]  op;
    logic [5:0]  addr;
    logic [7:0]  data;
    logic        addr_ok;
    logic [15:0] result;
    logic [3:0]  tx_idx;

    always_comb begin
        op      = rx_word[15:14];
        addr    = rx_word[13:8];
        data    = rx_word[7:0];
        addr_ok = ({1'b0, addr} < REG_LIMIT);
        tx_idx  = 4'd15 - bit_cnt[3:0];
        result  = 16'h0000;
        case (op)
            OP_CONVERT: result = {addr, frame_count[9:0]};
            OP_CALIB:   result = 16'h0000;
            OP_WRITE:   result = {WRITE_ACK_TAG, data};
            OP_READ:    result = addr_ok ? {8'h00, reg_file[addr]} : 16'h0000;
            default:    result = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            bit_cnt     <= 5'd0;
            rx_word     <= 16'h0000;
            tx_word     <= 16'h0000;
            miso_q      <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            last_cmd    <= 16'h0000;
            frame_count <= 32'd0;
            for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= 16'h0000;
            for (int i = 0; i < REG_SLOTS; i++) reg_file[i] <= 8'h00;
        end else begin
            frame_valid <= accept;
            frame_err   <= abort;
            if (load_frame) begin
                bit_cnt <= 5'd0;
                tx_word <= pipe[PIPE_DEPTH-1];
                miso_q  <= pipe[PIPE_DEPTH-1][15];
            end
            if (shift_bit) begin
                rx_word <= {rx_word[14:0], mosi_s};
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (drive_bit) miso_q <= tx_word[tx_idx];
            if (accept || abort) miso_q <= 1'b0;
            if (accept) begin
                last_cmd    <= rx_word;
                frame_count <= frame_count + 32'd1;
                pipe[0]     <= result;
                for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
                if (op == OP_WRITE && addr_ok) reg_file[addr] <= data;
            end
        end
    end

    assign spi.MISO_from_sensor = miso_q;

    a_params: assert property (@(posedge clk)
        FRAME_BITS == 16 && PIPE_DEPTH >= 1 && PIPE_DEPTH <= 3 && REG_COUNT >= 1 && REG_COUNT <= 64);
endmodule

// File: tb/tb_spi_sensor_responder.sv
// tb/tb_spi_sensor_responder.sv - directed bench with a command-level sensor model and per-cycle output compare
module tb_spi_sensor_responder;
    localparam int PD   = 2;
    localparam int REGS = 32;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    spi_sensor_responder_if spi();
    logic        frame_valid, frame_err;
    logic [15:0] last_cmd;
    logic [31:0] frame_count;

    spi_sensor_responder #(.PIPE_DEPTH(PD), .REG_COUNT(REGS), .FRAME_BITS(16)) dut (
        .clk(clk), .reset_b(reset_b), .spi(spi),
        .frame_valid(frame_valid), .last_cmd(last_cmd),
        .frame_err(frame_err), .frame_count(frame_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit settled = 1'b0;
    bit idle_chk = 1'b0;
    int fv_cnt = 0;
    int fe_cnt = 0;

    // Sensor model: what each accepted command returns, and when.
    logic [15:0] resp_q[$];
    logic [7:0]  m_regs [REGS];
    logic [31:0] m_count;
    logic [15:0] m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        resp_q.delete();
        for (int i = 0; i < PD; i++) resp_q.push_back(16'h0000);
        for (int i = 0; i < REGS; i++) m_regs[i] = 8'h00;
        m_count = 32'd0;
        m_last  = 16'h0000;
    endfunction

    function automatic void model_accept(input logic [15:0] cmd);
        int          r;
        logic [7:0]  d;
        logic [15:0] res;
        logic [9:0]  cnt_lo;
        r      = int'(cmd[13:8]);
        d      = cmd[7:0];
        cnt_lo = m_count[9:0];
        res    = 16'h0000;
        case (cmd[15:14])
            2'b00: res = {cmd[13:8], cnt_lo};
            2'b01: res = 16'h0000;
            2'b10: begin
                if (r < REGS) m_regs[r] = d;
                res = {8'hFF, d};
            end
            default: res = (r < REGS) ? {8'h00, m_regs[r]} : 16'h0000;
        endcase
        m_count = m_count + 32'd1;
        m_last  = cmd;
        resp_q.push_back(res);
        void'(resp_q.pop_front());
    endfunction

    always @(negedge clk) begin
        if (!settled) begin
            if (frame_valid) fv_cnt++;
            if (frame_err)   fe_cnt++;
        end else begin
            check("frame_count", frame_count, m_count);
            check("last_cmd", {16'h0, last_cmd}, {16'h0, m_last});
            check("frame_valid quiet", {31'h0, frame_valid}, 32'h0);
            check("frame_err quiet", {31'h0, frame_err}, 32'h0);
        end
        if (idle_chk) check("miso idle", {31'h0, spi.MISO_from_sensor}, 32'h0);
    end

    task automatic do_reset(input int cyc);
        settled = 1'b0;
        idle_chk = 1'b0;
        fv_cnt = 0;
        fe_cnt = 0;
        reset_b = 1'b0;
        spi.CS_b_wire = 1'b1;
        spi.SCLK_wire = 1'b0;
        spi.MOSI_to_sensor = 1'b0;
        model_reset();
        repeat (cyc) @(negedge clk);
        check("rst miso", {31'h0, spi.MISO_from_sensor}, 32'h0);
        check("rst frame_count", frame_count, 32'h0);
        check("rst last_cmd", {16'h0, last_cmd}, 32'h0);
        check("rst frame_valid", {31'h0, frame_valid}, 32'h0);
        check("rst frame_err", {31'h0, frame_err}, 32'h0);
        reset_b = 1'b1;
        repeat (6) @(negedge clk);
        check("no frame_err around reset", fe_cnt, 0);
        check("no frame_valid around reset", fv_cnt, 0);
        settled = 1'b1;
        idle_chk = 1'b1;
    endtask

    // Shifts nbits out as master; MISO is sampled just before each rising SCLK.
    task automatic send_frame(input logic [15:0] cmd, input int nbits,
                              input bit chk_lit, input logic [15:0] lit);
        logic [15:0] cap;
        logic [15:0] exp_w;
        cap = 16'h0000;
        exp_w = resp_q[0];
        @(negedge clk);
        idle_chk = 1'b0;
        spi.CS_b_wire = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi.MOSI_to_sensor = (i < 16) ? cmd[15-i] : 1'b1;
            repeat (6) @(negedge clk);
            if (i < 16) cap[15-i] = spi.MISO_from_sensor;
            spi.SCLK_wire = 1'b1;
            repeat (6) @(negedge clk);
            spi.SCLK_wire = 1'b0;
        end
        repeat (6) @(negedge clk);
        fv_cnt = 0;
        fe_cnt = 0;
        settled = 1'b0;
        spi.CS_b_wire = 1'b1;
        repeat (8) @(negedge clk);
        if (nbits >= 16) begin
            check("miso word vs model", {16'h0, cap}, {16'h0, exp_w});
            if (chk_lit) check("miso word literal", {16'h0, cap}, {16'h0, lit});
            check("frame_valid pulse", fv_cnt, 1);
            check("frame_err absent", fe_cnt, 0);
            model_accept(cmd);
        end else begin
            check("short frame_valid absent", fv_cnt, 0);
            check("short frame_err pulse", fe_cnt, 1);
        end
        settled = 1'b1;
        idle_chk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        spi.CS_b_wire = 1'b1;
        spi.SCLK_wire = 1'b0;
        spi.MOSI_to_sensor = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(5);
        repeat (100) @(negedge clk);
        check("idle frame_count", frame_count, 32'd0);

        // Pipeline latency
        send_frame(16'h0300, 16, 1'b1, 16'h0000);
        send_frame(16'h4000, 16, 1'b1, 16'h0000);
        send_frame(16'h4000, 16, 1'b1, 16'h0C00);
        send_frame(16'h4000, 16, 1'b1, 16'h0000);
        check("frame_count after 4", frame_count, 32'd4);

        // Write then read back
        send_frame(16'h85A7, 16, 1'b0, 16'h0000);
        send_frame(16'hC500, 16, 1'b0, 16'h0000);
        send_frame(16'h4000, 16, 1'b1, 16'hFFA7);
        send_frame(16'h4000, 16, 1'b1, 16'h00A7);

        // Out-of-range address; r8 must not alias r40
        send_frame(16'hA855, 16, 1'b0, 16'h0000);
        send_frame(16'hE800, 16, 1'b0, 16'h0000);
        send_frame(16'h4000, 16, 1'b1, 16'hFF55);
        send_frame(16'hC800, 16, 1'b1, 16'h0000);
        send_frame(16'h4000, 16, 1'b0, 16'h0000);
        send_frame(16'h4000, 16, 1'b1, 16'h0000);

        // Short frame leaves the pipeline untouched
        send_frame(16'h3F00, 16, 1'b0, 16'h0000);
        send_frame(16'h0100, 9, 1'b0, 16'h0000);
        check("frame_count after short", frame_count, 32'd15);
        send_frame(16'h4000, 16, 1'b1, 16'h0000);
        send_frame(16'h4000, 16, 1'b1, 16'hFC0E);

        // Reset mid-frame at bit 7
        @(negedge clk);
        idle_chk = 1'b0;
        spi.CS_b_wire = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            spi.MOSI_to_sensor = i[0];
            repeat (6) @(negedge clk);
            spi.SCLK_wire = 1'b1;
            repeat (6) @(negedge clk);
            spi.SCLK_wire = 1'b0;
        end
        do_reset(5);

        // Over-clocked frame: only the first 16 bits count
        send_frame(16'h8312, 20, 1'b1, 16'h0000);
        check("overclock last_cmd", {16'h0, last_cmd}, 32'h0000_8312);
        check("overclock frame_count", frame_count, 32'd1);
        send_frame(16'hC300, 16, 1'b1, 16'h0000);
        send_frame(16'h4000, 16, 1'b1, 16'hFF12);
        send_frame(16'h4000, 16, 1'b1, 16'h0012);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_sensor_responder.md
Name: spi_sensor_responder

Overview:
- Synthesizable SPI slave that emulates the sensor at the far end of main's SPI link.
- Consumes MOSI_to_sensor, SCLK_wire and CS_b_wire, and drives MISO_from_sensor.
- Decodes 16-bit commands (CONVERT / WRITE / READ) against a small register file.
- Returns each command's result PIPE_DEPTH frames later, as the real sensor does; used in mainTB and as an FPGA loopback target.

Parameters:
PIPE_DEPTH, 2, frames between a command and its result on MISO (legal 1..3)
REG_COUNT, 32, number of 8-bit registers (legal 1..64)
FRAME_BITS, 16, bits per SPI frame (fixed at 16; the parameter exists for assertions only)

Ports:
clk  in  1  system clock (100 MHz in the bench)
reset_b  in  1  asynchronous, active-low reset
SCLK_wire  in  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0)
CS_b_wire  in  1  active-low chip select
MOSI_to_sensor  in  1  command bit from master
MISO_from_sensor  out  1  result bit to master
frame_valid  out  1  one-clk pulse when a complete 16-bit frame is accepted
last_cmd  out  16  last accepted command word
frame_err  out  1  one-clk pulse when a frame is aborted short
frame_count  out  32  accepted frames since reset; wraps at 2^32

Behaviour:
Input synchronisation and timing
- SCLK, CS_b and MOSI each pass through a 2-FF synchronizer.
- Edges are detected on the synced values.
- The master must hold SCLK high and low for at least 4 clk each.
- Edge-to-action latency is 3 clk from the pin.

Reset
- Reset is asynchronous and active-low.
- Values in reset: MISO_from_sensor=0, frame_valid=0, frame_err=0, last_cmd=0, frame_count=0.
- All pipeline slots are 0; all registers are 0; FSM is in IDLE.

FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on synced CS_b falling edge. On entry: bit_cnt=0, tx_word=pipe[oldest], MISO=tx_word[15].
- In SHIFT, on SCLK rising edge: rx_word={rx_word[14:0],MOSI}, bit_cnt+1.
- In SHIFT, on SCLK falling edge with bit_cnt in 1..15: MISO=tx_word[15-bit_cnt].
- SHIFT -> DONE when bit_cnt reaches 16.
- In DONE, further SCLK edges are ignored. MISO holds the last bit.
- DONE -> IDLE on CS_b rising edge; the frame is accepted on that edge:
  - decode rx_word;
  - push the result into the pipeline;
  - last_cmd=rx_word;
  - frame_count+1;
  - frame_valid pulses on the same cycle.
- SHIFT -> IDLE on CS_b rising edge with bit_cnt<16:
  - frame_err pulses;
  - the pipeline and registers are unchanged;
  - frame_count is unchanged.
- MISO_from_sensor=0 whenever the FSM is in IDLE.

Command decode (bits [15:14] = op, r = bits [13:8], d = bits [7:0])
- 00 CONVERT channel r: result = {r[5:0], frame_count[9:0]}, using frame_count before the increment.
- 01 CALIBRATE: result = 16'h0000; no state change.
- 10 WRITE: reg[r]=d if r<REG_COUNT, otherwise ignored; result = {8'hFF, d}, regardless of whether the write took effect.
- 11 READ: result = {8'h00, reg[r]} if r<REG_COUNT, else 16'h0000. READ sees the value of any WRITE accepted earlier, including the immediately preceding frame.

Result pipeline
- PIPE_DEPTH-entry shift register.
- The frame N result appears on MISO during frame N+PIPE_DEPTH.
- The first PIPE_DEPTH frames after reset return 16'h0000.

Simultaneous events
- CS_b rising and an SCLK edge in the same clk: the CS_b edge wins and the SCLK edge is ignored.
- CS_b falling while the FSM is not in IDLE is impossible by construction; treat it as IDLE re-entry.

Reset mid-frame
- Immediate return to IDLE with all reset values.
- The partial frame is discarded without a frame_err pulse.

Decomposition:
- Shared package spi_sensor_pkg holds:
  - op encodings OP_CONVERT=2'b00, OP_CALIB=2'b01, OP_WRITE=2'b10, OP_READ=2'b11;
  - the FSM state typedef;
  - the WRITE_ACK_TAG=8'hFF constant.
- One natural sub-module, spi_sync_edge: a 2-FF synchronizer plus rise/fall pulse outputs, instantiated for SCLK and CS_b, with only the synchronizer used for MOSI.

Test Plan:
1. Reset then idle: hold reset_b=0 for 5 clk, release -> MISO=0, frame_count=0, no frame_valid pulses for 100 clk.
2. Pipeline latency: send frames CONVERT ch3 (16'h0300), CALIB (16'h4000), CALIB, CALIB with PIPE_DEPTH=2 -> frames 1-2 return 16'h0000; frame 3 returns 16'h0C00 ({6'd3, 10'd0}); frame_count=4.
3. Write/read: WRITE r5=8'hA7 (16'h85A7), READ r5 (16'hC500), two CALIBs -> frame 3 MISO=16'hFFA7, frame 4 MISO=16'h00A7.
4. Out-of-range address with REG_COUNT=32: WRITE r40=8'h55 (16'hA855), READ r40 (16'hE800), two CALIBs -> frame 3 MISO=16'hFF55, frame 4 MISO=16'h0000; no register changes.
5. Short frame: drop CS_b after 9 SCLK -> frame_err single pulse; frame_count and pipeline unchanged; the next full frame returns the previously queued result.
6. Reset mid-frame and over-clocked frame:
   - assert reset_b at bit 7 -> all outputs return to reset values, no frame_err;
   - a following 20-SCLK frame is accepted as one frame made of its first 16 bits.
